// File: rtl/turbo_scheduler.sv
// turbo_scheduler: selects the CPU speed code that feeds the clock-enable generator.
// Speed requests are captured on turbo_wr and applied only on a clk175en edge, so the
// selection never changes inside a 16-cycle block. force_slow pins the CPU at 3.5 MHz.
// Once it is released the CPU stays slow for HOLDOFF further clk175en pulses, then
// returns to the captured target.
//
// Parameters
//   HOLDOFF         clk175en pulses spent slow after force_slow falls (1..65535)
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   clk175en        phase-0 pulse, one cycle in every 16
//   turbo_req[1:0]  requested speed: 00=3.5 MHz, 01=7 MHz, 10=14 MHz, 11=full clock
//   turbo_wr        one-cycle strobe that captures turbo_req
//   force_slow      level; holds the CPU at 3.5 MHz while high
//   turbo_option    registered speed selection
//   change_pending  a captured target is waiting to be applied
//   slow_forced     force_slow is active or its holdoff is still running
`timescale 1ns/1ps
module turbo_scheduler #(
  parameter int unsigned HOLDOFF = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk175en,
  input  logic [1:0] turbo_req,
  input  logic       turbo_wr,
  input  logic       force_slow,
  output logic [1:0] turbo_option,
  output logic       change_pending,
  output logic       slow_forced
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SPD_W = 2;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_FORCED  = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [SPD_W-1:0] SPEED_SLOW = SPD_W'(0);

  logic [1:0]       state_q,    state_d;
  logic [SPD_W-1:0] target_q,   target_d;
  logic [SPD_W-1:0] option_q,   option_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pending_q,  pending_d;
  logic             slow_q,     slow_d;

  // A write that lands on the same edge as an apply is not part of that apply; if it
  // differs from what is being applied, it waits for the next clk175en.
  logic             wr_differs_from_target;
  assign wr_differs_from_target = turbo_wr && (turbo_req != target_q);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      target_q   <= SPEED_SLOW;
      option_q   <= SPEED_SLOW;
      hold_cnt_q <= '0;
      pending_q  <= 1'b0;
      slow_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      option_q   <= option_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
      slow_q     <= slow_d;
    end
  end

  // Next-state, target capture and speed selection.
  always_comb begin
    state_d    = state_q;
    target_d   = turbo_wr ? turbo_req : target_q;
    option_d   = option_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (force_slow) begin
          state_d = ST_FORCED;
          if (clk175en) option_d = SPEED_SLOW;
        end else if (turbo_wr && (turbo_req != option_q)) begin
          // Even with clk175en this cycle, the new value waits a full block.
          state_d = ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (force_slow) begin
          state_d = ST_FORCED;
          if (clk175en) option_d = SPEED_SLOW;
        end else if (clk175en) begin
          option_d = target_q;
          state_d  = wr_differs_from_target ? ST_PENDING : ST_RUN;
        end
      end

      ST_FORCED: begin
        if (clk175en) option_d = SPEED_SLOW;
        if (!force_slow) begin
          // The holdoff count always restarts in full; no credit from earlier holds.
          state_d    = ST_HOLD;
          hold_cnt_d = CNT_W'(HOLDOFF);
        end
      end

      ST_HOLD: begin
        if (force_slow) begin
          state_d = ST_FORCED;
          if (clk175en) option_d = SPEED_SLOW;
        end else if (clk175en) begin
          if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - CNT_W'(1);
          if (hold_cnt_q <= CNT_W'(1)) begin
            option_d = target_q;
            state_d  = wr_differs_from_target ? ST_PENDING : ST_RUN;
          end else begin
            option_d = SPEED_SLOW;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase

    slow_d    = (state_d == ST_FORCED) || (state_d == ST_HOLD);
    pending_d = (state_d == ST_PENDING) || (slow_d && (target_d != SPEED_SLOW));
  end

  assign turbo_option   = option_q;
  assign change_pending = pending_q;
  assign slow_forced    = slow_q;

endmodule

// File: doc/turbo_scheduler.md
TURBO_SCHEDULER -- requirements
Module: turbo_scheduler

Interface
REQ-001 Parameter HOLDOFF, default 256: number of clk175en pulses to wait after force_slow drops before leaving 3.5 MHz; legal range 1..65535.
REQ-002 clk  input  1  system clock; all enables below are single-cycle pulses in this domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clk175en  input  1  phase-0 pulse, high exactly 1 cycle in every 16; the only instant at which turbo_option may change.
REQ-005 turbo_req  input  2  requested CPU speed: 00=3.5 MHz, 01=7 MHz, 10=14 MHz, 11=full clock.
REQ-006 turbo_wr  input  1  one-cycle strobe; captures turbo_req.
REQ-007 force_slow  input  1  level; while high, CPU speed is held at 3.5 MHz (tape I/O, timing-critical peripherals).
REQ-008 turbo_option  output  2  registered speed selection driving the clock-enable generator.
REQ-009 change_pending  output  1  high while a captured target differs from turbo_option and is waiting to be applied.
REQ-010 slow_forced  output  1  high in states FORCED and HOLD.

Function
REQ-011 Internal registers: target[1:0], state {RUN, PENDING, FORCED, HOLD}, hold_cnt[15:0].
REQ-012 turbo_wr=1 loads target <= turbo_req on that edge, in every state.
REQ-013 turbo_option updates only on an edge where clk175en=1; new value visible the cycle after that edge; never changes mid 16-cycle block.
REQ-014 RUN: turbo_wr with turbo_req != turbo_option -> PENDING; turbo_wr with equal value -> stay RUN.
REQ-015 PENDING: on clk175en, turbo_option <= target, -> RUN.
REQ-016 turbo_wr and clk175en in the same cycle from RUN: value captured, applied at the following clk175en (16 cycles later), not the current one.
REQ-017 turbo_wr during PENDING overwrites target; latest write wins; writing back the current turbo_option value still applies at next clk175en (no-op) then RUN.
REQ-018 force_slow=1 in RUN or PENDING -> FORCED; turbo_option <= 00 at next clk175en (same-cycle clk175en does count); target kept.
REQ-019 FORCED: while force_slow=1, turbo_option stays 00; writes update target only.
REQ-020 FORCED with force_slow=0 -> HOLD, hold_cnt <= HOLDOFF.
REQ-021 HOLD: each clk175en decrements hold_cnt; on the clk175en where hold_cnt=1, turbo_option <= target, -> RUN.
REQ-022 force_slow=1 during HOLD -> FORCED; hold_cnt reloaded on next exit (restart, no accumulation).
REQ-023 force_slow and turbo_wr same cycle: force wins for turbo_option; target still updated.
REQ-024 change_pending = (state==PENDING) or (state in {FORCED,HOLD} and target != 00).
REQ-025 If target=00 when leaving HOLD, turbo_option is unchanged (00) and state -> RUN.
REQ-026 hold_cnt never wraps; decrement only when nonzero.

Reset
REQ-027 rst_n low asynchronously sets turbo_option=00, target=00, state=RUN, hold_cnt=0, change_pending=0, slow_forced=0.
REQ-028 Reset mid-change discards target; after release the block is in RUN and obeys REQ-013 from the first clk175en.
REQ-029 No output glitches on rst_n deassertion; first possible turbo_option change is at a clk175en edge after at least one turbo_wr.

Verification
REQ-030 Reset, free-running clk175en; turbo_wr with turbo_req=10 at phase 5 -> change_pending=1; turbo_option=10 one cycle after next clk175en; change_pending=0.
REQ-031 turbo_wr=1, turbo_req=11 coincident with clk175en -> turbo_option stays 00 for 16 further cycles, becomes 11 after the next clk175en.
REQ-032 turbo_option=01, force_slow=1 for 40 cycles, HOLDOFF=4 -> turbo_option=00 at next clk175en; slow_forced=1; turbo_option returns to 01 after 4th clk175en following force_slow fall.
REQ-033 In HOLD with hold_cnt=2, pulse force_slow one cycle -> FORCED, then full HOLDOFF count restarts; turbo_option stays 00 throughout.
REQ-034 Writes 01 then 11 then 10 within one 16-cycle block -> only 10 applied; exactly one turbo_option transition.
REQ-035 Assert rst_n low while PENDING with target=11 -> all outputs 0 immediately, no later spontaneous change.
